// File: rtl/ras_pkg.sv
// ras_pkg: class encoding, opcode fields and link registers
// shared by the return-address-stack predecoder.
package ras_pkg;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_CALL,
    CLS_RET
  } ras_class_e;

  typedef enum logic {
    ST_RUN,
    ST_SQUASH
  } ras_state_e;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [2:0] F3_JALR  = 3'b000;

  localparam logic [1:0] OP_32    = 2'b11;
  localparam logic [1:0] C_Q1     = 2'b01;
  localparam logic [1:0] C_Q2     = 2'b10;
  localparam logic [2:0] C_F3_JAL = 3'b001;
  localparam logic [2:0] C_F3_JR  = 3'b100;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

endpackage

// File: rtl/ras_classify.sv
// ras_classify: combinational call/return detector for one fetch beat.
// Compressed jumps are recognised only when RAS_RVC_EN is defined.
module ras_classify
  import ras_pkg::*;
(
  input  logic [31:0] instr_i,
  output ras_class_e  class_o,
  output logic        compressed_o
);

  logic [6:0] op;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [2:0] f3;
  logic       is_jal;
  logic       is_jalr;
  logic       unused_hi;

  assign compressed_o = instr_i[1:0] != OP_32;
  assign op  = instr_i[6:0];
  assign rd  = instr_i[11:7];
  assign f3  = instr_i[14:12];
  assign rs1 = instr_i[19:15];

  assign is_jal  = op == OPC_JAL;
  assign is_jalr = (op == OPC_JALR) && (f3 == F3_JALR);

  // immediate bits never affect the class
  assign unused_hi = ^instr_i[31:20];

`ifdef RAS_RVC_EN
  logic c_jal;
  logic c_jr_form;

  assign c_jal = (instr_i[1:0] == C_Q1)
              && (instr_i[15:13] == C_F3_JAL);

  // C.JR / C.JALR: rs2 == 0, rs1 != 0, bit 12 selects link
  assign c_jr_form = (instr_i[1:0] == C_Q2)
                  && (instr_i[15:13] == C_F3_JR)
                  && (instr_i[6:2] == REG_X0)
                  && (instr_i[11:7] != REG_X0);
`endif

  // one-hot decode of the jump forms into a class
  always_comb begin
    class_o = CLS_NONE;
    unique case (1'b1)
`ifdef RAS_RVC_EN
      c_jal: class_o = CLS_CALL;
      c_jr_form: begin
        if (instr_i[12])
          class_o = CLS_CALL;
        else if (is_link(instr_i[11:7]))
          class_o = CLS_RET;
      end
`endif
      is_jal: begin
        if (is_link(rd))
          class_o = CLS_CALL;
      end
      is_jalr: begin
        if (is_link(rd))
          class_o = CLS_CALL;
        else if ((rd == REG_X0) && is_link(rs1))
          class_o = CLS_RET;
      end
      default: class_o = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/ras_predecode.sv
// ras_predecode: one-stage fetch predecoder driving RAS push/pop and
// return redirects. Define RAS_RVC_EN to also predecode compressed jumps.
module ras_predecode
  import ras_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_valid,
  output logic        OUT_ready,
  input  logic [30:0] IN_pc,
  input  logic [31:0] IN_instr,
  input  logic        IN_flush,
  input  logic        IN_rasValid,
  input  logic [30:0] IN_rasData,
  output logic        OUT_push,
  output logic [30:0] OUT_pushData,
  output logic        OUT_pop,
  output logic        OUT_redirect,
  output logic [30:0] OUT_redirectPc,
  output logic        OUT_valid,
  input  logic        IN_ready,
  output logic [30:0] OUT_pc,
  output logic [31:0] OUT_instr
);

  localparam int unsigned CW =
    (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SQUASH_CYCLES);
  localparam bit HAS_SQ = SQUASH_CYCLES != 0;

  ras_class_e    cls;
  logic          is_c;
  ras_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          push_q;
  logic          pop_q;
  logic          redir_q;
  logic [30:0]   pushd_q;
  logic [30:0]   redirpc_q;
  logic          valid_q;
  logic [30:0]   pc_q;
  logic [31:0]   instr_q;

  logic          acc;
  logic          keep;
  logic          do_call;
  logic          do_ret;
  logic [30:0]   link;

  ras_classify u_cls (
    .instr_i      (IN_instr),
    .class_o      (cls),
    .compressed_o (is_c)
  );

  assign OUT_ready = rst & ~IN_flush & ~push_q
                   & (~valid_q | IN_ready);

  assign acc     = IN_valid & OUT_ready;
  assign keep    = acc & (state_q == ST_RUN);
  assign do_call = keep & (cls == CLS_CALL);
  assign do_ret  = keep & (cls == CLS_RET) & IN_rasValid;
  assign link    = IN_pc + (is_c ? 31'd1 : 31'd2);

  // redirect/squash FSM with registered RAS strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      redir_q   <= 1'b0;
      pushd_q   <= '0;
      redirpc_q <= '0;
    end else if (IN_flush) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      push_q  <= do_call;
      pop_q   <= do_ret;
      redir_q <= do_ret;
      if (do_call)
        pushd_q <= link;
      if (do_ret)
        redirpc_q <= IN_rasData;
      unique case (state_q)
        ST_RUN: begin
          if (do_ret && HAS_SQ) begin
            state_q <= ST_SQUASH;
            cnt_q   <= CNT_INIT;
          end
        end
        ST_SQUASH: begin
          if (acc) begin
            if (cnt_q > CW'(1)) begin
              cnt_q <= cnt_q - CW'(1);
            end else begin
              cnt_q   <= '0;
              state_q <= ST_RUN;
            end
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // single instruction stage towards decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (IN_flush) begin
      valid_q <= 1'b0;
    end else if (keep) begin
      valid_q <= 1'b1;
      pc_q    <= IN_pc;
      instr_q <= IN_instr;
    end else if (IN_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign OUT_push       = push_q;
  assign OUT_pushData   = pushd_q;
  assign OUT_pop        = pop_q;
  assign OUT_redirect   = redir_q;
  assign OUT_redirectPc = redirpc_q;
  assign OUT_valid      = valid_q;
  assign OUT_pc         = pc_q;
  assign OUT_instr      = instr_q;

endmodule

// File: tb/tb_ras_predecode.sv
// tb_ras_predecode: directed scenarios plus random traffic checked
// against a beat-level reference model of the predecoder.
module tb_ras_predecode;

  localparam int SQ = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IN_valid = 1'b0;
  logic [30:0] IN_pc = '0;
  logic [31:0] IN_instr = '0;
  logic        IN_flush = 1'b0;
  logic        IN_rasValid = 1'b0;
  logic [30:0] IN_rasData = '0;
  logic        IN_ready = 1'b0;
  logic        OUT_ready;
  logic        OUT_push;
  logic [30:0] OUT_pushData;
  logic        OUT_pop;
  logic        OUT_redirect;
  logic [30:0] OUT_redirectPc;
  logic        OUT_valid;
  logic [30:0] OUT_pc;
  logic [31:0] OUT_instr;

  int errs = 0;
  int checks = 0;

  // reference model state
  bit          mv;
  bit          mpush;
  bit          mpop;
  bit          mredir;
  logic [30:0] mpc;
  logic [31:0] minstr;
  logic [30:0] mpushd;
  logic [30:0] mredirpc;
  int          msq;

  ras_predecode #(.SQUASH_CYCLES(SQ)) dut (
    .clk            (clk),
    .rst            (rst),
    .IN_valid       (IN_valid),
    .OUT_ready      (OUT_ready),
    .IN_pc          (IN_pc),
    .IN_instr       (IN_instr),
    .IN_flush       (IN_flush),
    .IN_rasValid    (IN_rasValid),
    .IN_rasData     (IN_rasData),
    .OUT_push       (OUT_push),
    .OUT_pushData   (OUT_pushData),
    .OUT_pop        (OUT_pop),
    .OUT_redirect   (OUT_redirect),
    .OUT_redirectPc (OUT_redirectPc),
    .OUT_valid      (OUT_valid),
    .IN_ready       (IN_ready),
    .OUT_pc         (OUT_pc),
    .OUT_instr      (OUT_instr)
  );

  always #5 clk = ~clk;

  // 0 = none, 1 = call, 2 = return
  function automatic int cls_of(input logic [31:0] w);
    int rd;
    int rs1;
    if (w[1:0] == 2'b11) begin
      rd  = int'(w[11:7]);
      rs1 = int'(w[19:15]);
      if (w[6:0] == 7'h6F)
        return (rd == 1 || rd == 5) ? 1 : 0;
      if (w[6:0] == 7'h67 && w[14:12] == 3'd0) begin
        if (rd == 1 || rd == 5) return 1;
        if (rd == 0 && (rs1 == 1 || rs1 == 5)) return 2;
      end
      return 0;
    end
`ifdef RAS_RVC_EN
    rs1 = int'(w[11:7]);
    if (w[1:0] == 2'b01 && w[15:13] == 3'b001) return 1;
    if (w[1:0] == 2'b10 && w[15:13] == 3'b100
        && w[6:2] == 5'd0 && rs1 != 0) begin
      if (w[12]) return 1;
      if (rs1 == 1 || rs1 == 5) return 2;
    end
`endif
    return 0;
  endfunction

  function automatic bit m_ready();
    return rst && !IN_flush && !mpush && (!mv || IN_ready);
  endfunction

  task automatic m_reset();
    mv = 0; mpush = 0; mpop = 0; mredir = 0; msq = 0;
    mpc = '0; minstr = '0; mpushd = '0; mredirpc = '0;
  endtask

  // advance one clock edge and the model alongside
  task automatic tick();
    bit acc, fl, rdy, rv;
    logic [30:0] pc, rd;
    logic [31:0] ins;
    int c;
    acc = IN_valid && m_ready();
    fl = IN_flush; rdy = IN_ready; rv = IN_rasValid;
    pc = IN_pc; ins = IN_instr; rd = IN_rasData;
    @(posedge clk);
    if (fl) begin
      mv = 0; mpush = 0; mpop = 0; mredir = 0; msq = 0;
    end else begin
      mpush = 0; mpop = 0; mredir = 0;
      if (mv && rdy) mv = 0;
      if (acc) begin
        if (msq > 0) begin
          msq--;
        end else begin
          mv = 1; mpc = pc; minstr = ins;
          c = cls_of(ins);
          if (c == 1) begin
            mpush = 1;
            mpushd = pc + ((ins[1:0] == 2'b11) ? 31'd2 : 31'd1);
          end
          if (c == 2 && rv) begin
            mpop = 1; mredir = 1; mredirpc = rd; msq = SQ;
          end
        end
      end
    end
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'd2;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return {r[31:12], pick_reg(), 7'h6F};
      1, 2: return {r[31:20], pick_reg(), 3'b000, pick_reg(), 7'h67};
      3: return {r[31:16], 3'b100, r[12], pick_reg(),
                 (r[0] ? 5'd0 : r[6:2]), 2'b10};
      4: return {r[31:16], 3'b001, r[12:2], 2'b01};
      default: return r;
    endcase
  endfunction

  task automatic test_reset();
    m_reset();
    IN_ready = 1'b1;
    #3;
    checks++;
    if ({OUT_ready, OUT_valid, OUT_push, OUT_pop, OUT_redirect} !== 5'b0) begin
      errs++;
      $display("FAIL reset_ctl got=%b exp=00000",
        {OUT_ready, OUT_valid, OUT_push, OUT_pop, OUT_redirect});
    end
    checks++;
    if ({OUT_pc, OUT_instr, OUT_pushData, OUT_redirectPc} !== '0) begin
      errs++;
      $display("FAIL reset_data pc=%h instr=%h", OUT_pc, OUT_instr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (OUT_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready got=%b exp=1", OUT_ready);
    end
  endtask

  task automatic test_call();
    IN_valid = 1; IN_pc = 31'h100; IN_instr = 32'h0000_00EF;
    #1;
    checks++;
    if (OUT_ready !== 1'b1) begin
      errs++; $display("FAIL call_acc_ready got=%b exp=1", OUT_ready);
    end
    tick();
    IN_pc = 31'h104; IN_instr = NOP;
    checks++;
    if (OUT_push !== 1'b1 || OUT_pushData !== 31'h102) begin
      errs++;
      $display("FAIL call_push got=%b/%h exp=1/102", OUT_push, OUT_pushData);
    end
    checks++;
    if (OUT_ready !== 1'b0) begin
      errs++; $display("FAIL call_ready_low got=%b exp=0", OUT_ready);
    end
    checks++;
    if (OUT_valid !== 1'b1 || OUT_instr !== 32'h0000_00EF) begin
      errs++;
      $display("FAIL call_fwd got=%b/%h exp=1/000000ef", OUT_valid, OUT_instr);
    end
    tick();
    checks++;
    if (OUT_push !== 1'b0) begin
      errs++; $display("FAIL call_push_once got=%b exp=0", OUT_push);
    end
    tick();
    checks++;
    if (OUT_valid !== 1'b1 || OUT_pc !== 31'h104) begin
      errs++;
      $display("FAIL call_next got=%b/%h exp=1/104", OUT_valid, OUT_pc);
    end
    IN_valid = 0;
    tick();
  endtask

  task automatic test_return();
    IN_valid = 1; IN_pc = 31'h200; IN_instr = 32'h0000_8067;
    IN_rasValid = 1; IN_rasData = 31'h2A0;
    tick();
    checks++;
    if ({OUT_pop, OUT_redirect} !== 2'b11 || OUT_redirectPc !== 31'h2A0) begin
      errs++;
      $display("FAIL ret_redirect got=%b%b/%h exp=11/2a0",
        OUT_pop, OUT_redirect, OUT_redirectPc);
    end
    IN_rasValid = 0; IN_instr = NOP;
    for (int i = 0; i < 2; i++) begin
      IN_pc = 31'h204 + 31'(2 * i);
      tick();
      checks++;
      if (OUT_valid !== 1'b0 || OUT_redirect !== 1'b0) begin
        errs++;
        $display("FAIL ret_drop%0d got=%b/%b exp=0/0", i, OUT_valid, OUT_redirect);
      end
    end
    IN_pc = 31'h208;
    tick();
    checks++;
    if (OUT_valid !== 1'b1 || OUT_pc !== 31'h208) begin
      errs++;
      $display("FAIL ret_resume got=%b/%h exp=1/208", OUT_valid, OUT_pc);
    end
    IN_valid = 0;
    tick();
  endtask

  task automatic test_ret_novalid();
    IN_valid = 1; IN_pc = 31'h300; IN_instr = 32'h0000_8067;
    IN_rasValid = 0; IN_rasData = 31'h3A0;
    tick();
    checks++;
    if ({OUT_pop, OUT_redirect} !== 2'b00) begin
      errs++;
      $display("FAIL ret_empty_strobe got=%b%b exp=00", OUT_pop, OUT_redirect);
    end
    checks++;
    if (OUT_valid !== 1'b1 || OUT_instr !== 32'h0000_8067) begin
      errs++;
      $display("FAIL ret_empty_fwd got=%b/%h exp=1/00008067", OUT_valid, OUT_instr);
    end
    IN_valid = 0;
    tick();
  endtask

  task automatic test_flush_squash();
    IN_valid = 1; IN_pc = 31'h400; IN_instr = 32'h0000_8067;
    IN_rasValid = 1; IN_rasData = 31'h500;
    tick();
    IN_rasValid = 0; IN_pc = 31'h404; IN_instr = NOP;
    tick();
    IN_flush = 1; IN_pc = 31'h410;
    #1;
    checks++;
    if (OUT_ready !== 1'b0) begin
      errs++; $display("FAIL flush_ready got=%b exp=0", OUT_ready);
    end
    tick();
    checks++;
    if ({OUT_valid, OUT_push, OUT_pop, OUT_redirect} !== 4'b0) begin
      errs++;
      $display("FAIL flush_clear got=%b exp=0000",
        {OUT_valid, OUT_push, OUT_pop, OUT_redirect});
    end
    IN_flush = 0; IN_pc = 31'h420;
    tick();
    checks++;
    if (OUT_valid !== 1'b1 || OUT_pc !== 31'h420) begin
      errs++;
      $display("FAIL flush_run got=%b/%h exp=1/420", OUT_valid, OUT_pc);
    end
    IN_valid = 0;
    tick();
  endtask

  task automatic test_reset_mid_redirect();
    IN_valid = 1; IN_pc = 31'h600; IN_instr = 32'h0000_80E7;
    IN_instr = 32'h0000_8067; IN_rasValid = 1; IN_rasData = 31'h123;
    tick();
    checks++;
    if (OUT_redirect !== 1'b1) begin
      errs++; $display("FAIL rst_pre_redirect got=%b exp=1", OUT_redirect);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({OUT_ready, OUT_valid, OUT_push, OUT_pop, OUT_redirect,
         OUT_redirectPc, OUT_pc, OUT_instr, OUT_pushData} !== '0) begin
      errs++;
      $display("FAIL rst_async got redir=%b pc=%h valid=%b",
        OUT_redirect, OUT_redirectPc, OUT_valid);
    end
    m_reset();
    IN_valid = 0; IN_rasValid = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (OUT_ready !== 1'b1) begin
      errs++; $display("FAIL rst_release_ready got=%b exp=1", OUT_ready);
    end
    IN_valid = 1; IN_pc = 31'h700; IN_instr = NOP;
    tick();
    checks++;
    if (OUT_valid !== 1'b1 || OUT_pc !== 31'h700) begin
      errs++;
      $display("FAIL rst_run got=%b/%h exp=1/700", OUT_valid, OUT_pc);
    end
    IN_valid = 0;
    tick();
  endtask

  task automatic test_rvc();
    IN_valid = 1; IN_pc = 31'h7FFF_FFFF; IN_instr = 32'h0000_2001;
    tick();
`ifdef RAS_RVC_EN
    checks++;
    if (OUT_push !== 1'b1 || OUT_pushData !== 31'h0) begin
      errs++;
      $display("FAIL rvc_wrap got=%b/%h exp=1/0", OUT_push, OUT_pushData);
    end
`else
    checks++;
    if (OUT_push !== 1'b0 || OUT_valid !== 1'b1 || OUT_instr !== 32'h2001) begin
      errs++;
      $display("FAIL rvc_none got=%b/%b/%h exp=0/1/00002001",
        OUT_push, OUT_valid, OUT_instr);
    end
`endif
    IN_valid = 0;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      IN_valid    = $urandom_range(0, 3) != 0;
      IN_ready    = $urandom_range(0, 3) != 0;
      IN_flush    = $urandom_range(0, 19) == 0;
      IN_pc       = ($urandom_range(0, 9) == 0) ? 31'h7FFF_FFFF : 31'($urandom);
      IN_instr    = gen_instr();
      IN_rasValid = $urandom_range(0, 1) == 1;
      IN_rasData  = 31'($urandom);
      #1;
      checks++;
      if (OUT_ready !== m_ready()) begin
        errs++;
        $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, OUT_ready, m_ready());
      end
      tick();
      checks++;
      if (OUT_valid !== mv || (mv && {OUT_pc, OUT_instr} !== {mpc, minstr})) begin
        errs++;
        $display("FAIL rnd_stage n=%0d got=%b/%h/%h exp=%b/%h/%h",
          n, OUT_valid, OUT_pc, OUT_instr, mv, mpc, minstr);
      end
      checks++;
      if (OUT_push !== mpush || (mpush && OUT_pushData !== mpushd)) begin
        errs++;
        $display("FAIL rnd_push n=%0d got=%b/%h exp=%b/%h",
          n, OUT_push, OUT_pushData, mpush, mpushd);
      end
      checks++;
      if (OUT_pop !== mpop || OUT_redirect !== mredir
          || (mredir && OUT_redirectPc !== mredirpc)) begin
        errs++;
        $display("FAIL rnd_redirect n=%0d got=%b%b/%h exp=%b%b/%h",
          n, OUT_pop, OUT_redirect, OUT_redirectPc, mpop, mredir, mredirpc);
      end
    end
    IN_valid = 0; IN_flush = 0; IN_ready = 1;
  endtask

  initial begin
    test_reset();
    test_call();
    test_return();
    test_ret_novalid();
    test_flush_squash();
    test_reset_mid_redirect();
    test_rvc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
